// File: rtl/rx_iq_pack.sv
// rx_iq_pack: re-pairs channel-interleaved CIC words into I/Q samples,
// applies a gain shift, rounds/saturates to OUT_W bits and buffers the
// pairs in a show-ahead FIFO. Back-pressures the CIC through in_ready.
// Optional build macro RX_IQ_SAT_CNT_EN adds the sat_cnt saturation counter.
module rx_iq_pack #(
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_channel,
   input  logic                    in_startofpacket,
   input  logic                    in_endofpacket,
   input  logic [1:0]              in_error,
   input  logic [3:0]              shift,
   output logic signed [OUT_W-1:0] out_i,
   output logic signed [OUT_W-1:0] out_q,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    seq_err,
   input  logic                    clr_err
`ifdef RX_IQ_SAT_CNT_EN
   ,
   output logic [15:0]             sat_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [32:0] ROUND = 33'd1 << (31 - OUT_W);

   typedef enum logic {WAIT_I, HAVE_I} state_t;

   state_t           state, state_nx;
   logic [31:0]      i_hold;
   logic [3:0]       sh_hold;
   logic             i_err;

   logic             accept, good_i, good_q, word_err;
   logic             load_i, pair_done, seq_evt;

   logic [OUT_W:0]   sc_i, sc_q;
   logic             stg_vld;
   logic [OUT_W-1:0] stg_i, stg_q;
   logic [1:0]       stg_sat;

   logic [OUT_W-1:0] mem_i [FIFO_DEPTH];
   logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, count;
   logic [AW+1:0]    occ_nx;
   logic             push, pop;

   // Shift, saturate, round half up, saturate, truncate; MSB of result flags saturation
   function automatic logic [OUT_W:0] scale(input logic [31:0] x, input logic [3:0] sh);
      logic [47:0] w;
      logic [31:0] s1;
      logic [32:0] r;
      logic [31:0] s2;
      logic        sat;
      w   = {{16{x[31]}}, x} << sh;
      sat = 1'b0;
      // w[47] still holds the sign: at most 15 of the 16 extension bits are shifted out
      if (w[47:31] != {17{w[31]}}) begin
         sat = 1'b1;
         s1  = w[47] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         s1 = w[31:0];
      end
      r = {s1[31], s1} + ROUND;
      if (r[32] != r[31]) begin
         sat = 1'b1;
         s2  = r[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         s2 = r[31:0];
      end
      return {sat, s2[31:32-OUT_W]};
   endfunction

   assign accept   = in_valid & in_ready;
   assign good_i   = ~in_channel & in_startofpacket & ~in_endofpacket;
   assign good_q   = in_channel & in_endofpacket & ~in_startofpacket;
   assign word_err = |in_error;

   // Pairing decode: classify the accepted word against the current state
   always_comb begin
      load_i    = 1'b0;
      pair_done = 1'b0;
      seq_evt   = 1'b0;
      state_nx  = state;
      if (accept) begin
         if (word_err) seq_evt = 1'b1;
         case (state)
            WAIT_I: begin
               if (good_i) begin
                  load_i   = 1'b1;
                  state_nx = HAVE_I;
               end else begin
                  seq_evt = 1'b1;
               end
            end
            HAVE_I: begin
               if (good_q) begin
                  pair_done = ~i_err & ~word_err;
                  state_nx  = WAIT_I;
               end else if (good_i) begin
                  load_i  = 1'b1;
                  seq_evt = 1'b1;
               end else begin
                  seq_evt = 1'b1;
               end
            end
            default: state_nx = WAIT_I;
         endcase
      end
   end

   // Pairing FSM state and held I word with its shift and error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= WAIT_I;
         i_hold  <= '0;
         sh_hold <= '0;
         i_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (load_i) begin
            i_hold  <= in_data;
            sh_hold <= shift;
            i_err   <= word_err;
         end
      end
   end

   assign sc_i = scale(i_hold, sh_hold);
   assign sc_q = scale(in_data, sh_hold);

   // Scale stage register: one completed, scaled pair in flight to the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg_vld <= 1'b0;
         stg_i   <= '0;
         stg_q   <= '0;
         stg_sat <= '0;
      end else begin
         stg_vld <= pair_done;
         if (pair_done) begin
            stg_i   <= sc_i[OUT_W-1:0];
            stg_q   <= sc_q[OUT_W-1:0];
            stg_sat <= {sc_q[OUT_W], sc_i[OUT_W]};
         end
      end
   end

   assign push      = stg_vld;
   assign count     = wr_ptr - rd_ptr;
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign out_i     = mem_i[rd_ptr[AW-1:0]];
   assign out_q     = mem_q[rd_ptr[AW-1:0]];

   // FIFO storage and pointers; space is guaranteed by in_ready so push is unconditional
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            mem_i[k] <= '0;
            mem_q[k] <= '0;
         end
      end else begin
         if (push) begin
            mem_i[wr_ptr[AW-1:0]] <= stg_i;
            mem_q[wr_ptr[AW-1:0]] <= stg_q;
            wr_ptr                <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy seen next cycle: FIFO entries plus a pair in the scale stage
   assign occ_nx = (AW+2)'(count) + (AW+2)'(push) + (AW+2)'(pair_done) - (AW+2)'(pop);

   // in_ready registered from next-cycle occupancy so a pop reopens it one cycle later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_ready <= 1'b0;
      else          in_ready <= (occ_nx < (AW+2)'(FIFO_DEPTH));
   end

   // Sticky error flag; a new error in the clear cycle keeps it set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     seq_err <= 1'b0;
      else if (seq_evt) seq_err <= 1'b1;
      else if (clr_err) seq_err <= 1'b0;
   end

`ifdef RX_IQ_SAT_CNT_EN
   logic [16:0] sat_sum;
   assign sat_sum = 17'(sat_cnt) + 17'(stg_sat[0]) + 17'(stg_sat[1]);

   // Saturating count of saturated components, counted as pairs enter the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     sat_cnt <= '0;
      else if (clr_err) sat_cnt <= '0;
      else if (push)    sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end
`endif

endmodule
